// File: rtl/hwpe_stream_width_downsizer.sv
// Serializes one wide HWPE-Stream word into DATA_WIDTH_IN/DATA_WIDTH_OUT narrow beats, LSB slice first.
// Define HWPE_STREAM_DOWNSIZER_SKIP_EMPTY_EN to skip beats whose strobe slice is all-zero.
module hwpe_stream_width_downsizer #(
    parameter int unsigned DATA_WIDTH_IN  = 128,
    parameter int unsigned DATA_WIDTH_OUT = 32
) (
    input  logic                                             clk_i,
    input  logic                                             rst_i,
    input  logic                                             clear_i,
    input  logic                                             push_valid_i,
    input  logic [DATA_WIDTH_IN-1:0]                         push_data_i,
    input  logic [DATA_WIDTH_IN/8-1:0]                       push_strb_i,
    output logic                                             push_ready_o,
    output logic                                             pop_valid_o,
    output logic [DATA_WIDTH_OUT-1:0]                        pop_data_o,
    output logic [DATA_WIDTH_OUT/8-1:0]                      pop_strb_o,
    input  logic                                             pop_ready_i,
    output logic                                             busy_o,
    output logic [$clog2(DATA_WIDTH_IN/DATA_WIDTH_OUT)-1:0]  beat_idx_o
);

    localparam int unsigned RATIO      = DATA_WIDTH_IN / DATA_WIDTH_OUT;
    localparam int unsigned IDX_W      = $clog2(RATIO);
    localparam int unsigned STRB_IN_W  = DATA_WIDTH_IN / 8;
    localparam int unsigned STRB_OUT_W = DATA_WIDTH_OUT / 8;

    typedef enum logic {EMPTY, SERIALIZE} state_e;

    state_e                     state;
    logic [DATA_WIDTH_IN-1:0]   buf_data;
    logic [STRB_IN_W-1:0]       buf_strb;
    logic [IDX_W-1:0]           beat_idx;
    logic [IDX_W-1:0]           last_idx;
    logic [DATA_WIDTH_OUT-1:0]  pop_data_q;
    logic [STRB_OUT_W-1:0]      pop_strb_q;

    logic [IDX_W-1:0]           load_first;
    logic [IDX_W-1:0]           load_last;
    logic [IDX_W-1:0]           next_idx;
    logic                       load_nz;
    logic                       at_last;
    logic                       load;

    function automatic logic [DATA_WIDTH_OUT-1:0] slice_data(input logic [DATA_WIDTH_IN-1:0] d,
                                                             input logic [IDX_W-1:0] idx);
        return d[idx*DATA_WIDTH_OUT +: DATA_WIDTH_OUT];
    endfunction

    function automatic logic [STRB_OUT_W-1:0] slice_strb(input logic [STRB_IN_W-1:0] s,
                                                         input logic [IDX_W-1:0] idx);
        return s[idx*STRB_OUT_W +: STRB_OUT_W];
    endfunction

`ifdef HWPE_STREAM_DOWNSIZER_SKIP_EMPTY_EN
    typedef logic [RATIO-1:0] mask_t;

    function automatic mask_t slice_mask(input logic [STRB_IN_W-1:0] s);
        mask_t m;
        for (int i = 0; i < int'(RATIO); i++) begin
            m[i] = |s[i*STRB_OUT_W +: STRB_OUT_W];
        end
        return m;
    endfunction

    // Priority encoder: lowest non-empty slice at or above lo, 0 when there is none.
    function automatic logic [IDX_W-1:0] lowest_from(input mask_t m, input int lo);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = int'(RATIO) - 1; i >= 0; i--) begin
            if (i >= lo && m[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    function automatic logic [IDX_W-1:0] highest(input mask_t m);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(RATIO); i++) begin
            if (m[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    mask_t push_mask;
    mask_t buf_mask;

    assign push_mask  = slice_mask(push_strb_i);
    assign buf_mask   = slice_mask(buf_strb);
    assign load_nz    = |push_mask;
    assign load_first = lowest_from(push_mask, 0);
    assign load_last  = highest(push_mask);
    assign next_idx   = lowest_from(buf_mask, int'(beat_idx) + 1);
`else
    assign load_nz    = 1'b1;
    assign load_first = '0;
    assign load_last  = IDX_W'(RATIO - 1);
    assign next_idx   = beat_idx + IDX_W'(1);
`endif

    assign at_last = (beat_idx == last_idx);

    // Ready never looks at push_valid_i; reset/clear force it low so a colliding word is not taken.
    assign push_ready_o = ~rst_i & ~clear_i & ((state == EMPTY) | (pop_ready_i & at_last));
    assign load         = push_valid_i & push_ready_o;

    assign pop_valid_o = (state == SERIALIZE);
    assign busy_o      = (state == SERIALIZE);
    assign pop_data_o  = pop_data_q;
    assign pop_strb_o  = pop_strb_q;
    assign beat_idx_o  = beat_idx;

    // NOTE: the wide buffer is a plain register, not a memory, so clearing it on reset is cheap and keeps
    //       stale data from ever reaching pop_data_o; all state uses <= so every flop sees pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state      <= EMPTY;
            buf_data   <= '0;
            buf_strb   <= '0;
            beat_idx   <= '0;
            last_idx   <= '0;
            pop_data_q <= '0;
            pop_strb_q <= '0;
        end else if (load) begin
            if (load_nz) begin
                state      <= SERIALIZE;
                buf_data   <= push_data_i;
                buf_strb   <= push_strb_i;
                beat_idx   <= load_first;
                last_idx   <= load_last;
                pop_data_q <= slice_data(push_data_i, load_first);
                pop_strb_q <= slice_strb(push_strb_i, load_first);
            end else begin
                state <= EMPTY;
            end
        end else if (state == SERIALIZE && pop_ready_i) begin
            if (at_last) begin
                state <= EMPTY;
            end else begin
                beat_idx   <= next_idx;
                pop_data_q <= slice_data(buf_data, next_idx);
                pop_strb_q <= slice_strb(buf_strb, next_idx);
            end
        end
    end

endmodule

// File: tb/tb_hwpe_stream_width_downsizer.sv
// Randomized bench for hwpe_stream_width_downsizer against a queue-of-beats reference model.
module tb_hwpe_stream_width_downsizer;

    localparam int DW_IN  = 128;
    localparam int DW_OUT = 32;
    localparam int RATIO  = DW_IN / DW_OUT;
    localparam int SW     = DW_OUT / 8;
    localparam logic [DW_IN-1:0] W1 = 128'h44444444_33333333_22222222_11111111;

    typedef struct {
        logic [DW_OUT-1:0] data;
        logic [SW-1:0]     strb;
        int                idx;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 clear = 1'b0;
    logic                 push_valid = 1'b0;
    logic [DW_IN-1:0]     push_data = '0;
    logic [DW_IN/8-1:0]   push_strb = '0;
    logic                 push_ready;
    logic                 pop_valid;
    logic [DW_OUT-1:0]    pop_data;
    logic [SW-1:0]        pop_strb;
    logic                 pop_ready = 1'b0;
    logic                 busy;
    logic [$clog2(RATIO)-1:0] beat_idx;

    beat_t q[$];
    int    checks = 0;
    int    failures = 0;
    bit    fresh = 1'b1;
    bit    last_accepted;

    hwpe_stream_width_downsizer #(
        .DATA_WIDTH_IN (DW_IN),
        .DATA_WIDTH_OUT(DW_OUT)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (clear),
        .push_valid_i(push_valid),
        .push_data_i (push_data),
        .push_strb_i (push_strb),
        .push_ready_o(push_ready),
        .pop_valid_o (pop_valid),
        .pop_data_o  (pop_data),
        .pop_strb_o  (pop_strb),
        .pop_ready_i (pop_ready),
        .busy_o      (busy),
        .beat_idx_o  (beat_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected beats of one accepted word, LSB slice first.
    task automatic load_word(input logic [DW_IN-1:0] d, input logic [DW_IN/8-1:0] s);
        beat_t b;
        for (int i = 0; i < RATIO; i++) begin
            b.data = DW_OUT'(d >> (i * DW_OUT));
            b.strb = SW'(s >> (i * SW));
            b.idx  = i;
`ifdef HWPE_STREAM_DOWNSIZER_SKIP_EMPTY_EN
            if (b.strb != '0) q.push_back(b);
`else
            q.push_back(b);
`endif
        end
    endtask

    task automatic check_outputs();
        check("busy", busy, q.size() != 0);
        check("pop_valid", pop_valid, q.size() != 0);
        if (q.size() != 0) begin
            check("pop_data", pop_data, q[0].data);
            check("pop_strb", pop_strb, q[0].strb);
            check("beat_idx", beat_idx, q[0].idx);
        end else if (fresh) begin
            check("reset_data", pop_data, 0);
            check("reset_strb", pop_strb, 0);
            check("reset_idx", beat_idx, 0);
        end
    endtask

    task automatic step(input logic pv, input logic [DW_IN-1:0] pd, input logic [DW_IN/8-1:0] ps,
                        input logic pr, input logic r, input logic c);
        bit exp_ready;
        push_valid = pv;
        push_data  = pd;
        push_strb  = ps;
        pop_ready  = pr;
        rst        = r;
        clear      = c;
        #1;
        exp_ready = !r && !c && (q.size() == 0 || (pr && q.size() == 1));
        check("push_ready", push_ready, exp_ready);
        @(posedge clk);
        last_accepted = pv && exp_ready;
        if (r || c) begin
            q.delete();
            fresh = 1'b1;
        end else begin
            if (q.size() != 0 && pr) q.delete(0);
            if (last_accepted) begin
                fresh = 1'b0;
                load_word(pd, ps);
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n, input logic pr);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, pr, 1'b0, 1'b0);
    endtask

    initial begin
        logic [DW_IN-1:0]   wd;
        logic [DW_IN/8-1:0] ws;
        bit                 pend;
        int                 n_acc;
        int                 budget;

        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b1);

        // Single word, no stall.
        step(1'b1, W1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        idle(5, 1'b1);

        // Three words back-to-back, valid held continuously.
        n_acc  = 0;
        budget = 0;
        wd     = {$urandom, $urandom, $urandom, $urandom};
        while (n_acc < 3 && budget < 40) begin
            step(1'b1, wd, 16'hFFFF, 1'b1, 1'b0, 1'b0);
            budget++;
            if (last_accepted) begin
                n_acc++;
                wd = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        check("b2b_accepted", n_acc, 3);
        idle(6, 1'b1);

        // Backpressure at beat 2.
        step(1'b1, W1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1);
        idle(5, 1'b0);
        idle(4, 1'b1);

        // Reset after beat 1 is handshaken, then a fresh word.
        step(1'b1, W1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1);
        step(1'b1, W1, 16'hFFFF, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b1);
        step(1'b1, ~W1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        idle(5, 1'b1);

        // Sparse and empty strobes.
        step(1'b1, W1, 16'h0F0F, 1'b1, 1'b0, 1'b0);
        idle(5, 1'b1);
        step(1'b1, W1, 16'h0000, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b1);
        step(1'b1, W1, 16'hF0F0, 1'b1, 1'b0, 1'b0);
        idle(5, 1'b1);

        // Randomized traffic with backpressure and occasional reset/clear.
        pend = 1'b0;
        wd   = '0;
        ws   = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!pend && $urandom_range(0, 2) != 0) begin
                pend = 1'b1;
                wd   = {$urandom, $urandom, $urandom, $urandom};
                case ($urandom_range(0, 5))
                    0, 1:    ws = 16'hFFFF;
                    2:       ws = 16'h0F0F;
                    3:       ws = 16'h0000;
                    default: ws = 16'($urandom);
                endcase
            end
            step(pend, wd, ws, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 99) == 0, $urandom_range(0, 99) == 0);
            if (last_accepted) pend = 1'b0;
        end
        idle(6, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
